tone_arbiter: RTL
=================

// Module: tone_arbiter
// PURPOSE
//  Shares the single PWM tone path (PWM_Control freq->period/duty, then PWM) between NUM_REQ
//  note sources (players, alarm, UI beeper). Round-robin picks one pending request, drives its
//  frequency for its duration in ms, then inserts a silent gap and frees the path.
//  Sits between the requesters and the PWM_Control/PWM pair; owns the PWM reset pulse.
// PARAMETERS
//  CLK_FREQ   50000000  system clock in Hz; 1 ms = CLK_FREQ/1000 cycles (integer division)
//  NUM_REQ    4         number of requesters, 2..8
//  FREQ_W     16        note frequency width in Hz; 0 = rest (silence)
//  DUR_W      11        note duration width in ms
//  GAP_MS     5         silent gap after every note in ms; 0 = no gap
// PORTS
//  clk          in   1               system clock, rising edge
//  reset        in   1               asynchronous, active-high
//  req          in   NUM_REQ         level request; requester i holds until its grant[i]
//  req_freq     in   NUM_REQ*FREQ_W  packed; requester i at [FREQ_W*i +: FREQ_W]
//  req_dur      in   NUM_REQ*DUR_W   packed; requester i at [DUR_W*i +: DUR_W], in ms
//  grant        out  NUM_REQ         one-hot 1-cycle pulse: note accepted, req may drop
//  done         out  NUM_REQ         one-hot 1-cycle pulse: granted note finished sounding
//  freq         out  FREQ_W          frequency to PWM_Control; 0 when silent
//  tone_restart out  1               1-cycle pulse, ORed into PWM reset on every freq change
//  busy         out  1               high in every state except IDLE
//  active_id    out  $clog2(NUM_REQ) index of the last granted requester
// BEHAVIOUR
//  - Reset (async): state IDLE; grant=0, done=0, freq=0, tone_restart=0, busy=0,
//    active_id=NUM_REQ-1, rr pointer=NUM_REQ-1 (requester 0 wins first), all counters 0.
//  - States IDLE, GRANT, PLAY, GAP; all outputs registered.
//  - IDLE: if |req, pick the first set bit scanning from (ptr+1) mod NUM_REQ upward with
//    wrap-around; latch that requester's freq and dur, set ptr and active_id -> GRANT.
//  - GRANT (1 cycle): grant[id]=1, freq<=latched freq, tone_restart=1, ms counters cleared -> PLAY.
//    Latency: req sampled high at IDLE edge N -> grant high during cycle N+1.
//  - PLAY: a ms prescaler pulses once every CLK_FREQ/1000 cycles; ms_cnt increments per pulse.
//    When ms_cnt==dur: done[id]=1, freq<=0, tone_restart=1 -> GAP (GAP_MS>0) or IDLE.
//    dur==0: the exit condition holds on the first PLAY cycle (freq set in GRANT is cleared;
//    exactly one PLAY cycle).
//  - GAP: freq=0; after GAP_MS ms pulses -> IDLE. Requests arriving in PLAY/GAP wait.
//  - PLAY length = dur*(CLK_FREQ/1000) cycles exactly (prescaler restarts on GRANT and GAP entry).
//  - req changes after grant are ignored; requesters are sampled only in IDLE.
//  - freq==0 from a requester is a rest: full grant/PLAY/done sequence with silent output.
//  - Simultaneous req: round-robin only; no requester gets two grants while another waits.
//  - Counter widths: prescaler $clog2(CLK_FREQ/1000); ms_cnt max(DUR_W, $clog2(GAP_MS+1)).
//    No overflow is possible.
//  - Reset mid-note: immediate return to reset values; no done pulse for the aborted note.
//  - tone_restart never asserts in two consecutive cycles.
// STRUCTURE
//  - tone_pkg: state encoding localparams, ms_cycles(CLK_FREQ) function, packed-slice helpers.
//  - Sub-module ms_tick (prescaler with sync clear, 1-cycle tick out), reused by the Player rework.
//  - Arbiter scan and FSM live in tone_arbiter; PWM_Control/PWM are instantiated by the parent.
// TESTING  (CLK_FREQ=10000 -> 10 cycles/ms, NUM_REQ=4, GAP_MS=2)
//  1. Reset; req=0001, freq0=440, dur0=3 -> grant=0001 next cycle; freq=440 for 30 cycles;
//     done=0001; freq=0 for 20 cycles; busy falls.
//  2. req=1111 held, each dur=1 -> grant order 0,1,2,3,0; each grant->next grant gap is
//     1(GRANT)+10+20+1(IDLE) cycles.
//  3. Grant to 2 with ptr=2, then req=1011 -> next grant is 3, then 0 (wrap), then 1.
//  4. dur=0, freq=1000 -> grant, done one cycle later, then 20-cycle gap; tone_restart pulses twice.
//  5. freq=0, dur=2 -> freq stays 0, done after 20 PLAY cycles; grant/done sequence as normal.
//  6. Assert reset 15 cycles into a dur=5 note -> freq=0, busy=0, grant=done=0 immediately;
//     no done; next req0 is granted normally.

Source files
------------

// File: rtl/tone_pkg.sv
// Shared types and helpers for the tone path: FSM state encoding,
// millisecond prescaler sizing and packed-bus slice arithmetic.
package tone_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_PLAY  = 2'd2,
    S_GAP   = 2'd3
  } tone_state_t;

  localparam int MS_PER_S = 1000;

  // Clock cycles per millisecond; never less than one so the prescaler still ticks.
  function automatic int ms_cycles(input int clk_freq);
    int c;
    c = clk_freq / MS_PER_S;
    return (c < 1) ? 1 : c;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // LSB position of element idx in a packed bus of width-sized fields.
  function automatic int slice_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/ms_tick.sv
// Millisecond prescaler: counts CYCLES clocks and flags the last one of each
// period. A synchronous clear restarts the period from zero.
module ms_tick #(
  parameter int CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Period counter; wraps after LAST, restarts on clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // The tick is not masked by clear: the caller uses it in the same cycle it
  // decides to clear, and ignores it in states where the count is meaningless.
  assign tick = (cnt == LAST);

endmodule

// File: rtl/tone_arbiter.sv
// Round-robin owner of the single PWM tone path. Picks one pending note
// source, plays its frequency for its duration in ms, inserts a silent gap,
// then frees the path. Pulses tone_restart whenever the tone changes.
module tone_arbiter
  import tone_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int NUM_REQ  = 4,
  parameter int FREQ_W   = 16,
  parameter int DUR_W    = 11,
  parameter int GAP_MS   = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*FREQ_W-1:0]    req_freq,
  input  logic [NUM_REQ*DUR_W-1:0]     req_dur,
  output logic [NUM_REQ-1:0]           grant,
  output logic [NUM_REQ-1:0]           done,
  output logic [FREQ_W-1:0]            freq,
  output logic                         tone_restart,
  output logic                         busy,
  output logic [$clog2(NUM_REQ)-1:0]   active_id
);

  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int MS_CYC = ms_cycles(CLK_FREQ);
  localparam int MS_W   = max_int(DUR_W, $clog2(GAP_MS + 1));
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  tone_state_t          state;
  logic [FREQ_W-1:0]    lat_freq;
  logic [DUR_W-1:0]     lat_dur;
  logic [MS_W-1:0]      ms_cnt;
  logic [MS_W-1:0]      ms_next;

  logic [FREQ_W-1:0]    freq_arr [NUM_REQ];
  logic [DUR_W-1:0]     dur_arr  [NUM_REQ];

  logic                 pick_valid;
  logic [ID_W-1:0]      pick_id;
  logic [ID_W-1:0]      scan_idx;

  logic                 tick;
  logic                 ms_clear;
  logic                 play_end;
  logic                 gap_end;

  // Unpack the per-requester frequency and duration fields.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign freq_arr[gi] = req_freq[slice_lsb(gi, FREQ_W) +: FREQ_W];
      assign dur_arr[gi]  = req_dur[slice_lsb(gi, DUR_W) +: DUR_W];
    end
  endgenerate

  // Round-robin scan from the requester after the last grant, with wrap.
  // Walking from the farthest offset to the nearest lets the nearest win.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    scan_idx   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      scan_idx = ID_W'((int'(active_id) + k) % NUM_REQ);
      if (req[scan_idx]) begin
        pick_valid = 1'b1;
        pick_id    = scan_idx;
      end
    end
  end

  // Millisecond accounting: ms_next is the count including this cycle's tick,
  // so PLAY ends on the exact cycle the dur-th millisecond completes. A zero
  // duration matches on the first PLAY cycle through ms_cnt itself.
  assign ms_next  = ms_cnt + MS_W'(tick);
  assign play_end = (ms_cnt == MS_W'(lat_dur)) || (ms_next == MS_W'(lat_dur));
  assign gap_end  = (ms_next == MS_W'(GAP_MS));
  assign ms_clear = (state == S_GRANT) || ((state == S_PLAY) && play_end);

  ms_tick #(
    .CYCLES (MS_CYC)
  ) u_ms_tick (
    .clk   (clk),
    .reset (reset),
    .clear (ms_clear),
    .tick  (tick)
  );

  // Arbiter FSM with registered outputs. active_id doubles as the
  // round-robin pointer since both always hold the last granted index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      grant        <= '0;
      done         <= '0;
      freq         <= '0;
      tone_restart <= 1'b0;
      busy         <= 1'b0;
      active_id    <= ID_W'(NUM_REQ - 1);
      lat_freq     <= '0;
      lat_dur      <= '0;
      ms_cnt       <= '0;
    end else begin
      grant        <= '0;
      done         <= '0;
      tone_restart <= 1'b0;
      case (state)
        S_IDLE: begin
          // Holding off while tone_restart is high keeps restart pulses
          // apart when there is no gap between notes.
          if (pick_valid && !tone_restart) begin
            state        <= S_GRANT;
            active_id    <= pick_id;
            lat_freq     <= freq_arr[pick_id];
            lat_dur      <= dur_arr[pick_id];
            grant        <= ONE_HOT0 << pick_id;
            tone_restart <= 1'b1;
            busy         <= 1'b1;
          end
        end
        S_GRANT: begin
          freq   <= lat_freq;
          ms_cnt <= '0;
          state  <= S_PLAY;
        end
        S_PLAY: begin
          if (play_end) begin
            done         <= ONE_HOT0 << active_id;
            freq         <= '0;
            tone_restart <= 1'b1;
            ms_cnt       <= '0;
            if (GAP_MS > 0) begin
              state <= S_GAP;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            ms_cnt <= ms_next;
          end
        end
        S_GAP: begin
          if (gap_end) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            ms_cnt <= '0;
          end else begin
            ms_cnt <= ms_next;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
